lsu_mem_port: RTL and testbench
===============================

// Module: lsu_mem_port
// PURPOSE
//  Load/store unit between the core's execute stage and the byte-addressed data memory (1-cycle
//  registered read, wr size code 0=none/1=byte/2=half/3=word). Accepts one request at a time
//  over valid/ready, range-checks it and drives the memory port. Loads are sign/zero-extended.
//  Returns one response per request (data or fault) over valid/ready.
// PARAMETERS
//  MEM_SIZE   1024  bytes of backing memory; power of two
//  BASE_ADDR  0     byte address mapped to memory location 0
// PORTS
//  clk          in   1   clock; all state on rising edge
//  rst          in   1   asynchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   unit can accept a request (high only in IDLE)
//  req_we       in   1   1=store, 0=load
//  req_funct3   in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  req_addr     in   32  byte address, any alignment
//  req_wdata    in   32  store data, low bytes used
//  resp_valid   out  1   response present
//  resp_ready   in   1   consumer takes response
//  resp_rdata   out  32  extended load data; 0 for stores and faults
//  resp_fault   out  1   request rejected (bad funct3 or out of range); no memory effect
//  mem_rd_addr  out  32  to memory rd_addr (offset from BASE_ADDR)
//  mem_rd_data  in   32  from memory rd_data (valid cycle after address)
//  mem_wr       out  2   to memory wr size code
//  mem_wr_addr  out  32  to memory wr_addr
//  mem_wr_data  out  32  to memory wr_data
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0,
//    mem_wr=0, mem_rd_addr/mem_wr_addr/mem_wr_data=0. Reset mid-request abandons it; no response.
//  - FSM: IDLE -> ACCESS -> (load ok) LOAD_DATA -> RESP; (store or fault) ACCESS -> RESP.
//  - IDLE: req_ready=1. Accept when req_valid&&req_ready at edge; latch we, funct3, addr, wdata.
//  - Decode: bytes = 1/2/4 from funct3[1:0]. Fault if funct3 not in legal set for the direction
//    (stores: 000/001/010; loads: 000/001/010/100/101), or addr < BASE_ADDR, or
//    (addr-BASE_ADDR)+bytes > MEM_SIZE. Range math in 33 bits; no wrap-around.
//  - ACCESS (1 cycle): mem_rd_addr = addr-BASE_ADDR. Store without fault: mem_wr = 1/2/3 for
//    B/H/W, mem_wr_addr = addr-BASE_ADDR, mem_wr_data = latched wdata. Otherwise mem_wr=0.
//  - mem_wr is nonzero only in ACCESS for a non-faulting store: exactly one write per store.
//  - LOAD_DATA (1 cycle): register resp_rdata from mem_rd_data: B/H sign-extend bit 7/15,
//    BU/HU zero-extend, W pass-through.
//  - RESP: resp_valid=1, resp_rdata/resp_fault stable until resp_ready; on resp_valid&&resp_ready
//    go IDLE, clear resp_valid. Next request accepted earliest the cycle after handshake.
//  - Latency accept edge -> resp_valid: load 3 cycles, store/fault 2 cycles (resp_ready held high).
//  - mem_rd_addr holds last value outside ACCESS/LOAD_DATA; mem_wr_addr/data don't-care at mem_wr=0.
//  - req signals ignored while req_ready=0.
// TESTING
//  1. SW 0xDEADBEEF @0x10, then LW @0x10 -> store resp rdata=0 fault=0; load rdata=0xDEADBEEF,
//     memory bytes 0x10..0x13 = EF BE AD DE; mem_wr=3 for exactly one cycle.
//  2. SB 0x80 @0x21, LB @0x21 -> 0xFFFFFF80; LBU -> 0x00000080; LH @0x20 after SH 0x8001
//     -> 0xFFFF8001; LHU -> 0x00008001.
//  3. Boundary, MEM_SIZE=1024: SH @0x3FE ok; SW @0x3FE -> fault=1, mem_wr stays 0, bytes
//     0x3FE/0x3FF unchanged; LW @0xFFFFFFFE -> fault (no 32-bit wrap).
//  4. Illegal funct3: store funct3=100, load funct3=011 -> fault=1, rdata=0, no write.
//  5. Backpressure: resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0;
//     new req_valid ignored; accept after release.
//  6. Assert rst during ACCESS of a SW -> mem_wr=0 immediately, no write, no response, req_ready=1.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit: one request at a time, range/funct3 checking, byte-addressed memory port,
// sign/zero extension of load data and a single valid/ready response per request.
module lsu_mem_port #(
  parameter int unsigned MEM_SIZE  = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic [1:0]  mem_wr,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, LOAD_DATA, RESP} state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic        f3_legal;
  logic [2:0]  nbytes;
  logic [32:0] off33;
  logic [32:0] end33;
  logic        req_fault;

  logic        we_p0;
  logic [2:0]  f3_p0;
  logic [31:0] off_p0;
  logic [31:0] wdata_p0;
  logic        fault_p0;
  logic [31:0] rdata_p1;
  logic        fault_p1;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] raw);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = raw[7:0];
    h = raw[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Request decode; the borrow out of the 33-bit subtraction flags addresses below BASE_ADDR
  always_comb begin
    f3_legal = 1'b0;
    nbytes   = 3'd4;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !req_we;
      default:                f3_legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    off33     = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    end33     = off33 + {30'h0, nbytes};
    req_fault = !f3_legal || off33[32] || (end33 > 33'(MEM_SIZE));
  end

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = ACCESS;
      ACCESS:    state_d = (!we_p0 && !fault_p0) ? LOAD_DATA : RESP;
      LOAD_DATA: state_d = RESP;
      RESP:      if (resp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    mem_wr     = 2'd0;
    if (state_q == ACCESS && we_p0 && !fault_p0) mem_wr = f3_p0[1:0] + 2'd1;
  end

  assign mem_rd_addr = off_p0;
  assign mem_wr_addr = off_p0;
  assign mem_wr_data = wdata_p0;
  assign resp_rdata  = rdata_p1;
  assign resp_fault  = fault_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_p0    <= 1'b0;
      f3_p0    <= 3'd0;
      off_p0   <= 32'h0;
      wdata_p0 <= 32'h0;
      fault_p0 <= 1'b0;
      rdata_p1 <= 32'h0;
      fault_p1 <= 1'b0;
    end else begin
      state_q <= state_d;
      // p0: request latched at accept
      if (accept) begin
        we_p0    <= req_we;
        f3_p0    <= req_funct3;
        off_p0   <= off33[31:0];
        wdata_p0 <= req_wdata;
        fault_p0 <= req_fault;
      end
      // p1: response formed from ACCESS (store/fault) or LOAD_DATA (load)
      if (state_q == ACCESS && (we_p0 || fault_p0)) begin
        rdata_p1 <= 32'h0;
        fault_p1 <= fault_p0;
      end
      if (state_q == LOAD_DATA) begin
        rdata_p1 <= load_ext(f3_p0, mem_rd_data);
        fault_p1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte memory model, reference model of expected memory image and
// responses, one per-cycle compare process and directed vectors with literal expectations.
module tb_lsu_mem_port;
  localparam int unsigned MEM  = 1024;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
  logic [1:0]  mem_wr;

  lsu_mem_port #(.MEM_SIZE(MEM), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          nwr;
    logic [1:0]  wcode;
  } exp_t;

  logic [7:0]  mem  [0:MEM-1];
  logic [7:0]  refm [0:MEM-1];
  exp_t        expq [$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  int          wr_cnt = 0;
  logic [1:0]  last_code = 2'd0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_fault = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory: registered little-endian read, sized write
  always @(posedge clk) begin
    logic [31:0] ra, wa;
    ra = mem_rd_addr;
    mem_rd_data <= {mem[10'(ra + 3)], mem[10'(ra + 2)], mem[10'(ra + 1)], mem[10'(ra)]};
    wa = mem_wr_addr;
    if (mem_wr != 2'd0) begin
      mem[10'(wa)] = mem_wr_data[7:0];
      if (mem_wr >= 2'd2) mem[10'(wa + 1)] = mem_wr_data[15:8];
      if (mem_wr == 2'd3) begin
        mem[10'(wa + 2)] = mem_wr_data[23:16];
        mem[10'(wa + 3)] = mem_wr_data[31:24];
      end
    end
  end

  // Reference: what a request must do to the memory image and what it must answer
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output exp_t x);
    longint off;
    int n;
    bit legal;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = longint'({32'h0, addr}) - longint'({32'h0, BASE});
    x.fault = !legal || off < 0 || off + n > longint'(MEM);
    x.rdata = 32'h0;
    x.nwr = 0;
    x.wcode = 2'd0;
    if (!x.fault) begin
      if (we) begin
        for (int i = 0; i < n; i++) refm[int'(off) + i] = wd[8*i +: 8];
        x.nwr = 1;
        x.wcode = (n == 1) ? 2'd1 : (n == 2) ? 2'd2 : 2'd3;
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refm[int'(off) + i];
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        x.rdata = v;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      wr_cnt = 0;
    end else begin
      if (mem_wr != 2'd0) begin
        wr_cnt++;
        last_code = mem_wr;
      end
      if (resp_valid && resp_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_fault", {31'h0, resp_fault}, {31'h0, e.fault});
          check("write_cycles", wr_cnt, e.nwr);
          if (e.nwr != 0) check("wr_code", {30'h0, last_code}, {30'h0, e.wcode});
        end
        last_rdata = resp_rdata;
        last_fault = resp_fault;
        wr_cnt = 0;
      end
    end
  end

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    exp_t x;
    int n;
    bit ok;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model(we, f3, addr, wd, x);
    expq.push_back(x);
    #1 req_valid = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin n = i; break; end
    end
    check("latency", n, (we || x.fault) ? 2 : 3);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    int bad;
    #200000;
    $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;
    int bad;
    for (int i = 0; i < MEM; i++) begin
      mem[i]  = 8'(i * 37 + 5);
      refm[i] = 8'(i * 37 + 5);
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_fault", {31'h0, resp_fault}, 32'd0);
    check("rst_mem_wr", {30'h0, mem_wr}, 32'd0);
    check("rst_mem_rd_addr", mem_rd_addr, 32'h0);
    check("rst_mem_wr_addr", mem_wr_addr, 32'h0);
    check("rst_mem_wr_data", mem_wr_data, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Word store then load
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw_rdata_lit", last_rdata, 32'h0);
    check("sw_fault_lit", {31'h0, last_fault}, 32'd0);
    check("sw_bytes_lit", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_lit", last_rdata, 32'hDEADBEEF);

    // Byte/half extension
    do_req(1'b1, 3'b000, 32'h21, 32'h00000080);
    do_req(1'b0, 3'b000, 32'h21, 32'h0);
    check("lb_lit", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h21, 32'h0);
    check("lbu_lit", last_rdata, 32'h00000080);
    do_req(1'b1, 3'b001, 32'h20, 32'h00008001);
    do_req(1'b0, 3'b001, 32'h20, 32'h0);
    check("lh_lit", last_rdata, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 32'h20, 32'h0);
    check("lhu_lit", last_rdata, 32'h00008001);
    do_req(1'b0, 3'b010, 32'h11, 32'h0);

    // Range boundaries
    do_req(1'b1, 3'b001, 32'h3FE, 32'h00001234);
    check("sh_top_fault_lit", {31'h0, last_fault}, 32'd0);
    do_req(1'b1, 3'b010, 32'h3FE, 32'hCAFEF00D);
    check("sw_top_fault_lit", {31'h0, last_fault}, 32'd1);
    check("top_bytes_lit", {16'h0, mem[16'h3FF], mem[16'h3FE]}, 32'h00001234);
    do_req(1'b0, 3'b010, 32'h3FC, 32'h0);
    check("lw_last_word_fault_lit", {31'h0, last_fault}, 32'd0);
    do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    check("lw_wrap_fault_lit", {31'h0, last_fault}, 32'd1);
    do_req(1'b0, 3'b000, 32'h400, 32'h0);

    // Illegal funct3
    do_req(1'b1, 3'b100, 32'h40, 32'h55555555);
    check("st_f3_fault_lit", {31'h0, last_fault}, 32'd1);
    do_req(1'b0, 3'b011, 32'h40, 32'h0);
    check("ld_f3_fault_lit", {31'h0, last_fault}, 32'd1);
    check("ld_f3_rdata_lit", last_rdata, 32'h0);

    // Backpressure with an ignored request during RESP
    @(posedge clk); #1 resp_ready = 1'b0;
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    held = resp_rdata;
    check("bp_rdata_lit", held, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h50; req_wdata = 32'h0BADF00D;
      @(negedge clk);
      check("bp_resp_valid", {31'h0, resp_valid}, 32'd1);
      check("bp_rdata_stable", resp_rdata, held);
      check("bp_req_ready", {31'h0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_after", {31'h0, req_ready}, 32'd1);
    check("bp_queue_empty", expq.size(), 32'd0);

    // Reset during ACCESS of a store
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h60; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_wr_before", {30'h0, mem_wr}, 32'd3);
    rst = 1'b1;
    #1;
    check("rst_mid_mem_wr", {30'h0, mem_wr}, 32'd0);
    check("rst_mid_req_ready", {31'h0, req_ready}, 32'd1);
    check("rst_mid_resp_valid", {31'h0, resp_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) bad++;
    end
    check("rst_mid_no_resp", bad, 32'd0);
    check("rst_mid_no_write", {mem[16'h63], mem[16'h62], mem[16'h61], mem[16'h60]},
          {refm[16'h63], refm[16'h62], refm[16'h61], refm[16'h60]});

    // Accepts normally after reset
    do_req(1'b0, 3'b010, 32'h3FC, 32'h0);

    bad = 0;
    for (int i = 0; i < MEM; i++) if (mem[i] !== refm[i]) bad++;
    check("mem_image", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
